// File: rtl/audio_delay_ctrl.sv
// audio_delay_ctrl
// ----------------
// Fixed-latency audio delay line controller in front of a simple dual-port
// block RAM. Every accepted sample passes through a four-cycle sequence:
// it is written, the sample delay_q positions older is read back, and that
// sample is emitted on m_data. m_data is zero while the line has not yet
// been filled since the last reset, flush or delay change.
//
// Ports
//   clk        : single clock for the controller and the RAM
//   reset      : asynchronous active-high reset
//   enable     : gates acceptance of new samples only
//   flush      : one-cycle pulse; clears write pointer, fill count, overrun
//   cfg_delay  : requested delay in samples (0..16383)
//   s_valid    : incoming sample strobe
//   s_data     : incoming sample
//   s_ready    : a sample offered this cycle is accepted
//   m_valid    : one-cycle pulse marking a delayed output sample
//   m_data     : delayed sample, or 0 while muted
//   overrun    : sticky; set when a sample is offered but cannot be taken
//   ram_cea    : RAM write enable
//   ram_ada    : RAM write address
//   ram_din    : RAM write data
//   ram_ceb    : RAM read enable
//   ram_adb    : RAM read address
//   ram_oce    : RAM output clock enable, held at 1
//   ram_dout   : RAM read data, valid the cycle after ram_ceb
module audio_delay_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic [13:0] cfg_delay,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [15:0] m_data,
  output logic        overrun,
  output logic        ram_cea,
  output logic [13:0] ram_ada,
  output logic [15:0] ram_din,
  output logic        ram_ceb,
  output logic [13:0] ram_adb,
  output logic        ram_oce,
  input  logic [15:0] ram_dout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_READ    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  localparam logic [13:0] FILL_MAX = 14'd16383;

  logic [1:0]  r_state;
  logic [13:0] r_wr_ptr;
  logic [13:0] r_fill_cnt;
  logic [13:0] r_delay_q;
  logic        r_flush_pend;
  logic        r_overrun;
  logic        r_m_valid;
  logic [15:0] r_m_data;
  logic        r_ram_cea;
  logic [13:0] r_ram_ada;
  logic [15:0] r_ram_din;
  logic        r_ram_ceb;
  logic [13:0] r_ram_adb;

  logic w_idle;
  logic w_ready;
  logic w_accept;
  logic w_ovr_set;
  logic w_clear;
  logic w_mute;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_ready   = w_idle && enable && !flush;
  assign w_accept  = s_valid && w_ready;
  assign w_ovr_set = s_valid && enable && !w_ready;
  // A flush seen mid-sequence is deferred to the CAPTURE edge so that the
  // in-flight sample still uses the old fill count, and the pointers are
  // already clean in the IDLE cycle that follows.
  assign w_clear   = (w_idle && flush) ||
                     ((r_state == ST_CAPTURE) && (r_flush_pend || flush));
  assign w_mute    = (r_fill_cnt < r_delay_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_fill_cnt   <= '0;
      r_delay_q    <= '0;
      r_flush_pend <= 1'b0;
      r_overrun    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_ram_cea    <= 1'b0;
      r_ram_ada    <= '0;
      r_ram_din    <= '0;
      r_ram_ceb    <= 1'b0;
      r_ram_adb    <= '0;
    end else begin
      // Strobes default low; write and read enables are one state each, so
      // they can never overlap.
      r_m_valid <= 1'b0;
      r_ram_cea <= 1'b0;
      r_ram_ceb <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_WRITE;
            r_delay_q <= cfg_delay;
            // A new delay invalidates the history: mute until refilled.
            if (cfg_delay != r_delay_q) begin
              r_fill_cnt <= '0;
            end
            r_ram_cea <= 1'b1;
            r_ram_ada <= r_wr_ptr;
            r_ram_din <= s_data;
          end
        end
        ST_WRITE: begin
          r_state   <= ST_READ;
          r_ram_ceb <= 1'b1;
          // Modulo-2^14 wrap comes for free from the 14-bit subtraction.
          r_ram_adb <= r_wr_ptr - r_delay_q;
        end
        ST_READ: begin
          r_state  <= ST_CAPTURE;
          r_wr_ptr <= r_wr_ptr + 14'd1;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_m_valid <= 1'b1;
          r_m_data  <= w_mute ? 16'd0 : ram_dout;
          if (r_fill_cnt != FILL_MAX) begin
            r_fill_cnt <= r_fill_cnt + 14'd1;
          end
        end
      endcase

      if (flush && ((r_state == ST_WRITE) || (r_state == ST_READ))) begin
        r_flush_pend <= 1'b1;
      end

      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end

      // Placed last so a clear overrides the pointer increment, the fill
      // increment and a simultaneous overrun set.
      if (w_clear) begin
        r_wr_ptr     <= '0;
        r_fill_cnt   <= '0;
        r_overrun    <= 1'b0;
        r_flush_pend <= 1'b0;
      end
    end
  end

  assign s_ready = w_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign overrun = r_overrun;
  assign ram_cea = r_ram_cea;
  assign ram_ada = r_ram_ada;
  assign ram_din = r_ram_din;
  assign ram_ceb = r_ram_ceb;
  assign ram_adb = r_ram_adb;
  assign ram_oce = 1'b1;

endmodule

// File: tb/tb_audio_delay_ctrl.sv
// tb_audio_delay_ctrl
// Drives the delay controller against a behavioural RAM. Expected outputs
// come from a sample-history model: each accepted sample is either muted
// (fewer than delay samples since the last clear) or equals the sample
// accepted delay positions earlier.
module tb_audio_delay_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        flush;
  logic [13:0] cfg_delay;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [15:0] m_data;
  logic        overrun;
  logic        ram_cea;
  logic [13:0] ram_ada;
  logic [15:0] ram_din;
  logic        ram_ceb;
  logic [13:0] ram_adb;
  logic        ram_oce;
  logic [15:0] ram_dout;

  audio_delay_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .cfg_delay (cfg_delay),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .overrun   (overrun),
    .ram_cea   (ram_cea),
    .ram_ada   (ram_ada),
    .ram_din   (ram_din),
    .ram_ceb   (ram_ceb),
    .ram_adb   (ram_adb),
    .ram_oce   (ram_oce),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: registered read, data valid the cycle after ram_ceb.
  logic [15:0] mem [0:16383];
  always @(posedge clk) begin
    if (ram_cea) mem[ram_ada] <= ram_din;
    if (ram_ceb) ram_dout <= mem[ram_adb];
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model state.
  typedef struct {
    int          due;
    logic [15:0] d;
  } exp_t;
  exp_t        expq[$];
  logic [15:0] hist[$];
  int          busy;     // cycles left in the current sequence
  int          n_since;  // samples taken since last clear
  int          dq;
  int          ptr;
  bit          pend;
  bit          ovr;
  int          e_ada, e_adb;
  logic [15:0] e_din;

  task automatic model_reset();
    busy = 0; n_since = 0; dq = 0; ptr = 0; pend = 0; ovr = 0;
    expq.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"},  m_data, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_ram_cea"}, ram_cea, 0);
    chk({tag, "_ram_ceb"}, ram_ceb, 0);
    chk({tag, "_ram_ada"}, ram_ada, 0);
    chk({tag, "_ram_adb"}, ram_adb, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
    chk({tag, "_ram_oce"}, ram_oce, 1);
  endtask

  // One clock cycle: drive at the falling edge, check outputs, advance model.
  task automatic step(input logic sv, input logic en, input logic fl,
                      input logic [15:0] d, input logic [13:0] cfg);
    bit          rdy, acc, oset, clr, mv;
    int          busy_old;
    logic [15:0] e;
    s_valid = sv; enable = en; flush = fl; s_data = d; cfg_delay = cfg;
    #1;
    rdy = (busy == 0) && en && !fl;
    chk("s_ready", s_ready, rdy);
    chk("ce_overlap", ram_cea & ram_ceb, 0);
    if (busy == 3) begin
      chk("wr_cea", ram_cea, 1);
      chk("wr_ada", ram_ada, e_ada);
      chk("wr_din", ram_din, e_din);
    end
    if (busy == 2) begin
      chk("rd_ceb", ram_ceb, 1);
      chk("rd_adb", ram_adb, e_adb);
    end
    mv = (expq.size() > 0) && (expq[0].due == cyc);
    chk("m_valid", m_valid, mv);
    if (mv) begin
      chk("m_data", m_data, expq[0].d);
      void'(expq.pop_front());
    end
    chk("overrun", overrun, ovr);

    acc      = sv && rdy;
    oset     = sv && en && !rdy;
    clr      = ((busy == 0) && fl) || ((busy == 1) && (pend || fl));
    busy_old = busy;
    if (acc) begin
      if (cfg != dq) n_since = 0;
      dq = cfg;
      hist.push_back(d);
      if (hist.size() > 16384) void'(hist.pop_front());
      if (n_since < dq || dq >= hist.size()) e = 16'd0;
      else e = hist[hist.size() - 1 - dq];
      if (n_since < 16383) n_since++;
      expq.push_back('{due: cyc + 4, d: e});
      e_ada = ptr;
      e_adb = (ptr - dq) & 16'h3FFF;
      e_din = d;
      ptr   = (ptr + 1) % 16384;
      busy  = 3;
    end else if (busy > 0) begin
      busy--;
    end
    if (busy_old >= 2 && fl) pend = 1;
    if (clr) begin
      pend = 0; n_since = 0; ovr = 0; ptr = 0;
    end else if (oset) begin
      ovr = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d, input logic [13:0] cfg);
    step(1, 1, 0, d, cfg);
    repeat (3) step(0, 1, 0, 16'h0, cfg);
  endtask

  logic [13:0] cur_cfg;

  initial begin
    reset = 1; enable = 0; flush = 0; cfg_delay = 0; s_valid = 0; s_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk_reset_outputs("rst");
    @(negedge clk);
    reset = 0;

    // Basic delay of 3: outputs 0,0,0,1,2.
    for (int i = 1; i <= 5; i++) send(i[15:0], 14'd3);
    // Zero delay pass-through.
    send(16'h7FFF, 14'd0);
    send(16'h1234, 14'd0);
    // Overrun: two consecutive strobes, second dropped; then flush.
    step(1, 1, 0, 16'hAAAA, 14'd0);
    step(1, 1, 0, 16'hBBBB, 14'd0);
    repeat (3) step(0, 1, 0, 16'h0, 14'd0);
    step(0, 1, 1, 16'h0, 14'd0);
    send(16'h0C0C, 14'd0);
    // Delay change 4 -> 2 after 10 samples.
    for (int i = 0; i < 10; i++) send(16'h0100 + i[15:0], 14'd4);
    for (int i = 10; i < 14; i++) send(16'h0100 + i[15:0], 14'd2);
    // Flush arriving during WRITE and during CAPTURE is deferred.
    step(1, 1, 0, 16'h5555, 14'd2);
    step(0, 1, 1, 16'h0, 14'd2);
    repeat (2) step(0, 1, 0, 16'h0, 14'd2);
    send(16'h6666, 14'd2);
    step(1, 1, 0, 16'h7777, 14'd2);
    step(1, 1, 0, 16'h0, 14'd2);
    step(0, 1, 0, 16'h0, 14'd2);
    step(1, 1, 1, 16'h0, 14'd2);
    // Flush and overrun set together in IDLE: clear wins.
    step(1, 1, 1, 16'h0, 14'd2);
    // Enable dropping mid-sequence does not abort it.
    step(1, 1, 0, 16'h4242, 14'd2);
    repeat (3) step(0, 0, 0, 16'h0, 14'd2);
    step(1, 0, 0, 16'h4343, 14'd2);

    // Randomized traffic.
    cur_cfg = 14'd3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) cur_cfg = 14'($urandom_range(0, 7));
      else if ($urandom_range(0, 999) == 0) cur_cfg = 14'($urandom_range(0, 16383));
      step(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 39) == 0), 16'($urandom), cur_cfg);
    end
    repeat (6) step(0, 1, 0, 16'h0, cur_cfg);

    // Reset asserted in the READ state: no pulse, outputs cleared at once.
    step(1, 1, 0, 16'h9999, 14'd1);
    step(0, 1, 0, 16'h0, 14'd1);
    s_valid = 0;
    reset = 1;
    #1;
    chk_reset_outputs("midread");
    model_reset();
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("midread_no_pulse", m_valid, 0);
    end
    @(negedge clk);
    reset = 0;

    // Wrap-around with delay 2, value = index.
    step(0, 1, 1, 16'h0, 14'd2);
    for (int i = 0; i < 16386; i++) send(i[15:0], 14'd2);
    repeat (6) step(0, 1, 0, 16'h0, 14'd2);

    chk("pending_outputs", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_delay_ctrl.md
AUDIO_DELAY_CTRL -- requirements
Module: audio_delay_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock for all logic and the BRAM (clka = clkb = clk).
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port enable, input, 1 bit: when low, no sample is accepted.
REQ-004 SHALL have port flush, input, 1 bit: single-cycle pulse that clears the pointer, fill count and overrun flag.
REQ-005 SHALL have port cfg_delay, input, 14 bits: delay in samples, 0..16383.
REQ-006 SHALL have port s_valid, input, 1 bit: incoming sample strobe from the ADC path.
REQ-007 SHALL have port s_data, input, 16 bits: incoming sample.
REQ-008 SHALL have port s_ready, output, 1 bit: high when a sample can be accepted.
REQ-009 SHALL have port m_valid, output, 1 bit: one-cycle pulse marking a delayed output sample.
REQ-010 SHALL have port m_data, output, 16 bits: delayed sample, or 0 while muted.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag set when s_valid is dropped.
REQ-012 SHALL have port ram_cea, output, 1 bit: BRAM write enable.
REQ-013 SHALL have port ram_ada, output, 14 bits: BRAM write address.
REQ-014 SHALL have port ram_din, output, 16 bits: BRAM write data.
REQ-015 SHALL have port ram_ceb, output, 1 bit: BRAM read enable.
REQ-016 SHALL have port ram_adb, output, 14 bits: BRAM read address.
REQ-017 SHALL have port ram_oce, output, 1 bit: tied to 1.
REQ-018 SHALL have port ram_dout, input, 16 bits: BRAM read data, valid 1 cycle after the cycle in which ram_ceb is high (bypass read mode).

Function
REQ-019 SHALL implement the FSM IDLE -> WRITE -> READ -> CAPTURE -> IDLE, advancing one state per clock.
REQ-020 s_ready SHALL equal (state == IDLE) && enable && !flush.
REQ-021 In IDLE, s_valid && s_ready SHALL latch s_data and cfg_delay into delay_q and move the FSM to WRITE.
REQ-022 In IDLE, if the latched cfg_delay differs from the previous delay_q, fill_cnt SHALL be cleared to 0.
REQ-023 In WRITE, the block SHALL drive ram_cea=1, ram_ada=wr_ptr and ram_din=latched sample.
REQ-024 In READ, the block SHALL drive ram_ceb=1 and ram_adb=(wr_ptr - delay_q) mod 2^14, then increment wr_ptr mod 2^14 (16383 wraps to 0).
REQ-025 In CAPTURE, the block SHALL set mute=(fill_cnt < delay_q) and register m_data = mute ? 0 : ram_dout.
REQ-026 In CAPTURE, the block SHALL pulse m_valid for exactly the next cycle and increment fill_cnt, saturating at 16383.
REQ-027 Latency SHALL be exactly 4 clocks from the accepting edge to m_valid high.
REQ-028 Throughput SHALL be at most 1 sample per 4 clocks; a new sample may be accepted in the cycle m_valid is high.
REQ-029 delay_q=0 SHALL return the sample just written (write precedes read), i.e. a pure 4-cycle pass-through that is never muted.
REQ-030 s_valid high while s_ready is low and enable is high SHALL set overrun=1; the sample SHALL be dropped and the FSM is unaffected.
REQ-031 A flush pulse in IDLE SHALL clear wr_ptr, fill_cnt and overrun in the next cycle.
REQ-032 A flush pulse outside IDLE SHALL be held pending and applied on return to IDLE, before any new acceptance; the in-flight sample completes normally.
REQ-033 If flush and a set condition for overrun occur in the same cycle, clear SHALL win.
REQ-034 enable going low mid-sequence SHALL NOT abort the sequence; it blocks only new acceptances.
REQ-035 ram_cea and ram_ceb SHALL never both be high in the same cycle.

Reset
REQ-036 Reset SHALL asynchronously force: state=IDLE, wr_ptr=0, fill_cnt=0, delay_q=0, flush pending=0, overrun=0, m_valid=0, m_data=0, ram_cea=0, ram_ceb=0, ram_ada=0, ram_adb=0, ram_din=0.
REQ-037 Reset asserted mid-sequence SHALL drop the in-flight sample with no m_valid pulse.
REQ-038 BRAM contents are not cleared by reset; after reset, output SHALL be muted until delay_q samples have been written.

Verification
REQ-039 Basic delay: cfg_delay=3, samples 1,2,3,4,5 spaced 4 clocks apart -> m_data 0,0,0,1,2, each pulse 4 clocks after acceptance.
REQ-040 Zero delay: cfg_delay=0, sample 0x7FFF -> m_data=0x7FFF after 4 clocks; ram_adb equals ram_ada of the preceding cycle.
REQ-041 Wrap-around: cfg_delay=2, 16386 samples with value = index -> after wr_ptr wraps, ram_adb=16383 then 0, and m_data continues as index-2 with no glitch.
REQ-042 Overrun: s_valid held high for 2 consecutive clocks -> second sample dropped, overrun=1; flush -> overrun=0, wr_ptr=0.
REQ-043 Delay change: after 10 samples at delay 4, set cfg_delay=2 -> next 2 outputs are 0, then sample n-2.
REQ-044 Reset mid-READ: reset asserted in the READ state -> no m_valid; all outputs match REQ-036 immediately.
